// File: rtl/ps2_key_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_event_gen
// Description : Converts a raw PS/2 set-2 scancode byte stream into the
//               11-bit ps2_key toggle event word {toggle, pressed, extended,
//               code}. Resolves E0/F0 prefixes, swallows the E1 Pause
//               sequence, drops fake-shift codes, filters keyboard status
//               bytes, and holds off input after each event so downstream
//               per-clock edge detectors always see every toggle.
// Ports       : clk_sys     - system clock
//               reset_n     - asynchronous reset, active-low
//               scan_valid  - scan_data holds a byte
//               scan_data   - raw scancode byte
//               scan_ready  - byte accepted when scan_valid & scan_ready
//               ps2_key     - {toggle, pressed, extended, code[7:0]}
//               key_evt     - one-cycle pulse with each ps2_key update
//               pause_evt   - one-cycle pulse after a full Pause sequence
//               err         - one-cycle pulse on a protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_event_gen #(
  parameter int HOLD_CYCLES     = 2,
  parameter int PAUSE_LEN       = 8,
  parameter int PREFIX_TIMEOUT  = 600000,
  parameter bit DROP_FAKE_SHIFT = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        scan_valid,
  input  logic [7:0]  scan_data,
  output logic        scan_ready,
  output logic [10:0] ps2_key,
  output logic        key_evt,
  output logic        pause_evt,
  output logic        err
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_EXT    = 3'd1;
  localparam logic [2:0] c_ST_BRK    = 3'd2;
  localparam logic [2:0] c_ST_EXTBRK = 3'd3;
  localparam logic [2:0] c_ST_PAUSE  = 3'd4;
  localparam logic [2:0] c_ST_HOLD   = 3'd5;

  localparam int c_HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int c_PAUSE_W = $clog2(PAUSE_LEN + 1);
  localparam int c_TO_W    = $clog2(PREFIX_TIMEOUT + 1);

  localparam logic [c_HOLD_W-1:0]  c_HOLD_LOAD  = c_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [c_PAUSE_W-1:0] c_PAUSE_LOAD = c_PAUSE_W'(PAUSE_LEN - 1);
  localparam logic [c_PAUSE_W-1:0] c_PAUSE_ONE  = c_PAUSE_W'(1);
  localparam logic [c_TO_W-1:0]    c_TO_LAST    = c_TO_W'(PREFIX_TIMEOUT - 1);

  logic [2:0]           r_state;
  logic [c_HOLD_W-1:0]  r_hold_cnt;
  logic [c_PAUSE_W-1:0] r_pause_cnt;
  logic [c_TO_W-1:0]    r_to_cnt;
  logic                 r_scan_ready;
  logic [10:0]          r_ps2_key;
  logic                 r_key_evt;
  logic                 r_pause_evt;
  logic                 r_err;

  logic       w_xfer;
  logic       w_is_prefix;
  logic       w_fake;
  logic       w_in_prefix;
  logic       w_to_expire;
  logic [2:0] w_next_state;
  logic       w_emit;
  logic       w_emit_pressed;
  logic       w_emit_ext;
  logic       w_err;
  logic       w_pause_load;
  logic       w_pause_done;

  assign w_xfer      = scan_valid & r_scan_ready;
  assign w_is_prefix = (scan_data == 8'hE0) | (scan_data == 8'hE1) | (scan_data == 8'hF0);
  // Fake shifts only matter once an E0 has been seen; callers qualify with ext.
  assign w_fake      = DROP_FAKE_SHIFT & ((scan_data == 8'h12) | (scan_data == 8'h59));
  assign w_in_prefix = (r_state == c_ST_EXT) | (r_state == c_ST_BRK) | (r_state == c_ST_EXTBRK);
  // An arriving byte always wins over an expiring timeout in the same cycle.
  assign w_to_expire = w_in_prefix & ~w_xfer & (r_to_cnt == c_TO_LAST);

  always_comb begin
    w_next_state   = r_state;
    w_emit         = 1'b0;
    w_emit_pressed = 1'b0;
    w_emit_ext     = 1'b0;
    w_err          = 1'b0;
    w_pause_load   = 1'b0;
    w_pause_done   = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (w_xfer) begin
          case (scan_data)
            8'hE0: w_next_state = c_ST_EXT;
            8'hF0: w_next_state = c_ST_BRK;
            8'hE1: begin
              w_next_state = c_ST_PAUSE;
              w_pause_load = 1'b1;
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE: w_next_state = c_ST_IDLE;
            8'h00, 8'hFF: w_err = 1'b1;
            default: begin
              w_emit         = 1'b1;
              w_emit_pressed = 1'b1;
            end
          endcase
        end
      end
      c_ST_EXT: begin
        if (w_xfer) begin
          if (scan_data == 8'hF0) begin
            w_next_state = c_ST_EXTBRK;
          end else if (scan_data == 8'hE0) begin
            // Repeated E0: flag it but keep waiting for the code byte.
            w_err = 1'b1;
          end else if (scan_data == 8'hE1) begin
            w_err        = 1'b1;
            w_next_state = c_ST_IDLE;
          end else if (w_fake) begin
            w_next_state = c_ST_IDLE;
          end else begin
            w_emit         = 1'b1;
            w_emit_pressed = 1'b1;
            w_emit_ext     = 1'b1;
          end
        end else if (w_to_expire) begin
          w_err        = 1'b1;
          w_next_state = c_ST_IDLE;
        end
      end
      c_ST_BRK, c_ST_EXTBRK: begin
        if (w_xfer) begin
          if (w_is_prefix) begin
            w_err        = 1'b1;
            w_next_state = c_ST_IDLE;
          end else if (w_fake && (r_state == c_ST_EXTBRK)) begin
            w_next_state = c_ST_IDLE;
          end else begin
            w_emit     = 1'b1;
            w_emit_ext = (r_state == c_ST_EXTBRK);
          end
        end else if (w_to_expire) begin
          w_err        = 1'b1;
          w_next_state = c_ST_IDLE;
        end
      end
      c_ST_PAUSE: begin
        if (w_xfer && (r_pause_cnt == c_PAUSE_ONE)) begin
          w_pause_done = 1'b1;
          w_next_state = c_ST_IDLE;
        end
      end
      c_ST_HOLD: begin
        if (r_hold_cnt == '0) begin
          w_next_state = c_ST_IDLE;
        end
      end
      default: w_next_state = c_ST_IDLE;
    endcase
    if (w_emit) begin
      w_next_state = c_ST_HOLD;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_ST_IDLE;
      r_hold_cnt   <= '0;
      r_pause_cnt  <= '0;
      r_to_cnt     <= '0;
      r_scan_ready <= 1'b0;
      r_ps2_key    <= '0;
      r_key_evt    <= 1'b0;
      r_pause_evt  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      // Registered so ready stays low through reset and rises one edge later.
      r_scan_ready <= (w_next_state != c_ST_HOLD);
      r_key_evt    <= w_emit;
      r_pause_evt  <= w_pause_done;
      r_err        <= w_err;

      if (w_emit) begin
        r_ps2_key <= {~r_ps2_key[10], w_emit_pressed, w_emit_ext, scan_data};
      end

      if (w_emit) begin
        r_hold_cnt <= c_HOLD_LOAD;
      end else if ((r_state == c_ST_HOLD) && (r_hold_cnt != '0)) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end

      if (w_pause_load) begin
        r_pause_cnt <= c_PAUSE_LOAD;
      end else if ((r_state == c_ST_PAUSE) && w_xfer) begin
        r_pause_cnt <= r_pause_cnt - 1'b1;
      end

      // Reloads on entry to a prefix state (entry is always a transfer) and
      // on every byte accepted while waiting.
      if (!w_in_prefix || w_xfer) begin
        r_to_cnt <= '0;
      end else if (!w_to_expire) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign scan_ready = r_scan_ready;
  assign ps2_key    = r_ps2_key;
  assign key_evt    = r_key_evt;
  assign pause_evt  = r_pause_evt;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_event_gen
// Description : Self-checking bench for ps2_key_event_gen. Directed scenarios
//               followed by randomized byte streams, all checked against a
//               prefix-flag / countdown reference model of the scancode rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_gen;

  localparam int HOLD_CYCLES     = 3;
  localparam int PAUSE_LEN       = 8;
  localparam int PREFIX_TIMEOUT  = 40;
  localparam bit DROP_FAKE_SHIFT = 1'b1;

  localparam int c_K_NONE  = 0;
  localparam int c_K_KEY   = 1;
  localparam int c_K_PAUSE = 2;
  localparam int c_K_ERR   = 3;

  logic        clk_sys;
  logic        reset_n;
  logic        scan_valid;
  logic [7:0]  scan_data;
  logic        scan_ready;
  logic [10:0] ps2_key;
  logic        key_evt;
  logic        pause_evt;
  logic        err;

  ps2_key_event_gen #(
    .HOLD_CYCLES     (HOLD_CYCLES),
    .PAUSE_LEN       (PAUSE_LEN),
    .PREFIX_TIMEOUT  (PREFIX_TIMEOUT),
    .DROP_FAKE_SHIFT (DROP_FAKE_SHIFT)
  ) u_dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .scan_valid (scan_valid),
    .scan_data  (scan_data),
    .scan_ready (scan_ready),
    .ps2_key    (ps2_key),
    .key_evt    (key_evt),
    .pause_evt  (pause_evt),
    .err        (err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_ext;
  bit          m_brk;
  int          m_pause_left;
  logic [10:0] m_key;
  int          m_ready_low;
  int          m_key_cnt;
  int          m_pause_cnt;
  int          m_err_cnt;

  // Pulse counters observed on the DUT outputs
  int mon_key_cnt   = 0;
  int mon_pause_cnt = 0;
  int mon_err_cnt   = 0;

  always @(posedge clk_sys) begin
    if (reset_n) begin
      if (key_evt)   mon_key_cnt++;
      if (pause_evt) mon_pause_cnt++;
      if (err)       mon_err_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ext        = 1'b0;
    m_brk        = 1'b0;
    m_pause_left = 0;
    m_key        = '0;
    m_ready_low  = 0;
  endtask

  function automatic bit is_fake(input logic [7:0] b);
    return DROP_FAKE_SHIFT && (b == 8'h12 || b == 8'h59);
  endfunction

  // Applies one accepted byte to the model; returns what the DUT should report.
  task automatic model_byte(input logic [7:0] b, output int kind);
    bit pressed;
    bit ext;
    bit is_pfx;
    kind    = c_K_NONE;
    pressed = 1'b0;
    ext     = 1'b0;
    is_pfx  = (b == 8'hE0) || (b == 8'hE1) || (b == 8'hF0);
    if (m_pause_left > 0) begin
      m_pause_left--;
      if (m_pause_left == 0) kind = c_K_PAUSE;
    end else if (!m_ext && !m_brk) begin
      if (b == 8'hE0)      m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE1) m_pause_left = PAUSE_LEN - 1;
      else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) kind = c_K_NONE;
      else if (b == 8'h00 || b == 8'hFF) kind = c_K_ERR;
      else begin kind = c_K_KEY; pressed = 1'b1; ext = 1'b0; end
    end else if (m_brk) begin
      if (is_pfx) begin
        kind = c_K_ERR; m_ext = 1'b0; m_brk = 1'b0;
      end else if (m_ext && is_fake(b)) begin
        m_ext = 1'b0; m_brk = 1'b0;
      end else begin
        kind = c_K_KEY; pressed = 1'b0; ext = m_ext;
      end
    end else begin
      if (b == 8'hF0)      m_brk = 1'b1;
      else if (b == 8'hE0) kind = c_K_ERR;
      else if (b == 8'hE1) begin kind = c_K_ERR; m_ext = 1'b0; end
      else if (is_fake(b)) m_ext = 1'b0;
      else begin kind = c_K_KEY; pressed = 1'b1; ext = 1'b1; end
    end
    if (kind == c_K_KEY) begin
      m_key       = {~m_key[10], pressed, ext, b};
      m_ext       = 1'b0;
      m_brk       = 1'b0;
      m_ready_low = HOLD_CYCLES;
      m_key_cnt++;
    end else begin
      m_ready_low = 0;
    end
    if (kind == c_K_PAUSE) m_pause_cnt++;
    if (kind == c_K_ERR)   m_err_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
    m_ready_low = (m_ready_low > n) ? (m_ready_low - n) : 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waits;
    int kind;
    waits = 0;
    @(negedge clk_sys);
    scan_valid = 1'b1;
    scan_data  = b;
    while (!scan_ready && waits < 60) begin
      @(negedge clk_sys);
      waits++;
    end
    check_val("ready_wait", waits, m_ready_low);
    if (!scan_ready) begin
      scan_valid = 1'b0;
      return;
    end
    @(posedge clk_sys);
    #1;
    scan_valid = 1'b0;
    model_byte(b, kind);
    check_val("key_evt",   {31'd0, key_evt},   {31'd0, kind == c_K_KEY});
    check_val("pause_evt", {31'd0, pause_evt}, {31'd0, kind == c_K_PAUSE});
    check_val("err",       {31'd0, err},       {31'd0, kind == c_K_ERR});
    check_val("ps2_key",   {21'd0, ps2_key},   {21'd0, m_key});
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 15);
    case (r)
      0, 1: return 8'hE0;
      2:    return 8'hF0;
      3:    return ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'hF0;
      4:    begin
        int s;
        s = $urandom_range(0, 3);
        return (s == 0) ? 8'hAA : (s == 1) ? 8'hFA : (s == 2) ? 8'hEE : 8'hFE;
      end
      5:    return ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      6:    return ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [10:0] key_before;
    int          k;
    logic [7:0]  pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    reset_n    = 1'b0;
    scan_valid = 1'b0;
    scan_data  = 8'h00;
    model_reset();
    m_key_cnt   = 0;
    m_pause_cnt = 0;
    m_err_cnt   = 0;

    repeat (3) @(negedge clk_sys);
    check_val("rst_ps2_key", {21'd0, ps2_key}, 32'd0);
    check_val("rst_outs", {28'd0, scan_ready, key_evt, pause_evt, err}, 32'd0);
    reset_n = 1'b1;
    #1;
    check_val("rst_rel_ready", {31'd0, scan_ready}, 32'd0);
    @(posedge clk_sys);
    #1;
    check_val("first_edge_ready", {31'd0, scan_ready}, 32'd1);

    // Make then break of a plain key
    send_byte(8'h1C);
    check_val("make_1c", {21'd0, ps2_key}, 32'h61C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check_val("break_1c", {21'd0, ps2_key}, 32'h01C);

    // Extended make/break, inputs presented back-to-back through the hold window
    send_byte(8'hE0);
    send_byte(8'h75);
    check_val("ext_make", {22'd0, ps2_key[9:0]}, 32'h375);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check_val("ext_break", {22'd0, ps2_key[9:0]}, 32'h175);
    idle(1);
    send_byte(8'h33);

    // Pause sequence leaves ps2_key untouched
    idle(5);
    key_before = ps2_key;
    for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
    check_val("pause_key_hold", {21'd0, ps2_key}, {21'd0, key_before});

    // Fake shift followed by a real extended key, then status bytes
    send_byte(8'hE0);
    send_byte(8'h12);
    send_byte(8'hE0);
    send_byte(8'h6B);
    check_val("fake_then_6b", {22'd0, ps2_key[9:0]}, 32'h36B);
    send_byte(8'hAA);
    send_byte(8'hFA);

    // Double break prefix is an error, recovery afterwards
    idle(4);
    send_byte(8'hF0);
    send_byte(8'hF0);
    send_byte(8'h29);
    check_val("after_err_29", {22'd0, ps2_key[9:0]}, 32'h229);

    // Abandoned E0 prefix times out
    idle(4);
    send_byte(8'hE0);
    k = 0;
    for (int c = 1; c <= 3 * PREFIX_TIMEOUT; c++) begin
      @(posedge clk_sys);
      #1;
      if (err) begin
        k = c;
        break;
      end
    end
    check_val("timeout_cycles", k, PREFIX_TIMEOUT);
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ready_low = 0;
    if (k != 0) m_err_cnt++;
    send_byte(8'h1D);

    // Asynchronous reset in the middle of E0 F0
    send_byte(8'hE0);
    send_byte(8'hF0);
    #3;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_key", {21'd0, ps2_key}, 32'd0);
    check_val("async_rst_outs", {28'd0, scan_ready, key_evt, pause_evt, err}, 32'd0);
    model_reset();
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    @(posedge clk_sys);
    #1;
    send_byte(8'h1C);
    check_val("post_rst_make", {21'd0, ps2_key}, 32'h61C);

    // Randomized byte stream with occasional idle gaps
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      send_byte(rand_byte());
    end
    idle(HOLD_CYCLES + 2);

    check_val("total_key_evts",   mon_key_cnt,   m_key_cnt);
    check_val("total_pause_evts", mon_pause_cnt, m_pause_cnt);
    check_val("total_err_evts",   mon_err_cnt,   m_err_cnt);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
